// File: rtl/rr_dff_arbiter.sv
// Round-robin arbiter feeding one shared W-bit register from N requesters.
// Latency: req seen at edge t -> gnt during t..t+1 -> out loaded at edge t+1; max one write per 2 cycles.
// Backpressure: a requester holds req/din until it sees its gnt bit; losers simply keep requesting.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous reset, active-high; overrides everything, including a grant in flight
//   req        req[i]=1: requester i wants to write the shared register
//   din        requester i word at din[i*W +: W]
//   gnt        one-hot grant, high for exactly the GRANT cycle
//   busy       high while the arbiter is in GRANT
//   out        shared register contents; changes only on the GRANT-exit edge
//   out_valid  0 after reset, 1 once the first write has completed
//   last_id    index of the most recent writer
module rr_dff_arbiter #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  din,
  output logic [N-1:0]    gnt,
  output logic            busy,
  output logic [W-1:0]    out,
  output logic            out_valid,
  output logic [IW-1:0]   last_id
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Registered state
  state_t          state_q,     state_d;
  logic [IW-1:0]   ptr_q,       ptr_d;       // highest-priority index for the next search
  logic [IW-1:0]   sel_q,       sel_d;       // requester holding the current grant
  logic [N-1:0]    gnt_q,       gnt_d;
  logic            busy_q,      busy_d;
  logic [W-1:0]    out_q,       out_d;
  logic            out_valid_q, out_valid_d;
  logic [IW-1:0]   last_id_q,   last_id_d;

  // Arbitration result
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;

  // Unpacked view of the requester words
  logic [W-1:0]    din_word [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      din_word[i] = din[i*W +: W];
    end
  end

  // Rotating search: start at ptr_q and walk upward modulo N, taking the
  // first requester found. Because ptr moves to sel+1 after every grant,
  // the most recent winner always ends up last in line.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr_q) + i) % N);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    gnt_d       = '0;
    busy_d      = 1'b0;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    last_id_d   = last_id_q;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d          = ST_GRANT;
          gnt_d[win_idx]   = 1'b1;
          busy_d           = 1'b1;
          sel_d            = win_idx;
        end
      end

      ST_GRANT: begin
        // The grant is a commitment: the write happens even if the owner has
        // already dropped req. din is taken on this edge, not at grant time.
        out_d       = din_word[sel_q];
        last_id_d   = sel_q;
        out_valid_d = 1'b1;
        ptr_d       = (sel_q == IW'(N - 1)) ? '0 : sel_q + IW'(1);
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      last_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      last_id_q   <= last_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign last_id   = last_id_q;

endmodule

// File: tb/tb_rr_dff_arbiter.sv
// Bench for rr_dff_arbiter (N=4, W=8): vector table plus hand-written multi-cycle sequences.
// Inputs change 1ns after the rising edge; outputs are checked at the same point after each edge.
// Every expectation is hand-computed from the arbiter's documented behaviour.
module tb_rr_dff_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*W-1:0] din;
  logic [N-1:0]  gnt;
  logic          busy;
  logic [W-1:0]  out;
  logic          out_valid;
  logic [1:0]    last_id;

  int n_total;
  int n_pass;

  rr_dff_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .busy      (busy),
    .out       (out),
    .out_valid (out_valid),
    .last_id   (last_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic           rst;
    logic [3:0]     req;
    logic [31:0]    din;
    logic [3:0]     gnt;
    logic           busy;
    logic [7:0]     out;
    logic           vld;
    logic [1:0]     last;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [3:0] q, logic [31:0] d, logic [3:0] g,
                              logic b, logic [7:0] o, logic v, logic [1:0] l);
    vec_t x;
    x.rst = r; x.req = q; x.din = d; x.gnt = g;
    x.busy = b; x.out = o; x.vld = v; x.last = l;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic b,
                         input logic [7:0] o, input logic v, input logic [1:0] l);
    chk({tag, " gnt"},       32'(gnt),       32'(g));
    chk({tag, " busy"},      32'(busy),      32'(b));
    chk({tag, " out"},       32'(out),       32'(o));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, " last_id"},   32'(last_id),   32'(l));
  endtask

  int gcount [N];
  logic prev_gnt_any;
  logic bad_onehot;
  logic back_to_back;

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset   = 1'b1;
    req     = '0;
    din     = '0;
    @(posedge clk); #1;
    step();
    chk_all("reset state", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);

    // Idle with no requests: nothing moves for 10 cycles
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("idle%0d gnt", c), 32'(gnt), 32'h0);
      chk($sformatf("idle%0d busy/out/vld", c), {22'h0, busy, out, out_valid}, 32'h0);
    end

    // Vector table: single request, hold, contention 0..3 with wrap, wrap fairness
    tbl.push_back(mk(1, 4'b0000, 32'h00000000, 4'b0000, 0, 8'h00, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0100, 32'h00A50000, 4'b0100, 1, 8'h00, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 32'h00A50000, 4'b0000, 0, 8'hA5, 1, 2'd2));
    tbl.push_back(mk(0, 4'b0000, 32'h00000000, 4'b0000, 0, 8'hA5, 1, 2'd2));
    tbl.push_back(mk(0, 4'b0000, 32'h00000000, 4'b0000, 0, 8'hA5, 1, 2'd2));
    tbl.push_back(mk(1, 4'b0000, 32'h00000000, 4'b0000, 0, 8'h00, 0, 2'd0));
    tbl.push_back(mk(0, 4'b1111, 32'h13121110, 4'b0001, 1, 8'h00, 0, 2'd0));
    tbl.push_back(mk(0, 4'b1111, 32'h13121110, 4'b0000, 0, 8'h10, 1, 2'd0));
    tbl.push_back(mk(0, 4'b1111, 32'h13121110, 4'b0010, 1, 8'h10, 1, 2'd0));
    tbl.push_back(mk(0, 4'b1111, 32'h13121110, 4'b0000, 0, 8'h11, 1, 2'd1));
    tbl.push_back(mk(0, 4'b1111, 32'h13121110, 4'b0100, 1, 8'h11, 1, 2'd1));
    tbl.push_back(mk(0, 4'b1111, 32'h13121110, 4'b0000, 0, 8'h12, 1, 2'd2));
    tbl.push_back(mk(0, 4'b1111, 32'h13121110, 4'b1000, 1, 8'h12, 1, 2'd2));
    tbl.push_back(mk(0, 4'b1111, 32'h13121110, 4'b0000, 0, 8'h13, 1, 2'd3));
    tbl.push_back(mk(0, 4'b1111, 32'h13121110, 4'b0001, 1, 8'h13, 1, 2'd3));
    tbl.push_back(mk(0, 4'b1111, 32'h13121110, 4'b0000, 0, 8'h10, 1, 2'd0));
    tbl.push_back(mk(0, 4'b1000, 32'h13121110, 4'b1000, 1, 8'h10, 1, 2'd0));
    tbl.push_back(mk(0, 4'b1001, 32'h13121110, 4'b0000, 0, 8'h13, 1, 2'd3));
    tbl.push_back(mk(0, 4'b1001, 32'h13121110, 4'b0001, 1, 8'h13, 1, 2'd3));
    tbl.push_back(mk(0, 4'b1001, 32'h13121110, 4'b0000, 0, 8'h10, 1, 2'd0));
    tbl.push_back(mk(0, 4'b1001, 32'h13121110, 4'b1000, 1, 8'h10, 1, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 32'h13121110, 4'b0000, 0, 8'h13, 1, 2'd3));

    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      req   = tbl[i].req;
      din   = tbl[i].din;
      step();
      chk_all($sformatf("row%0d", i), tbl[i].gnt, tbl[i].busy, tbl[i].out, tbl[i].vld, tbl[i].last);
    end
    reset = 1'b0;
    req   = '0;

    // Starvation: all four request for 20 cycles; each must win at least twice,
    // grants must be one-hot and never on consecutive cycles.
    reset = 1'b1; step(); reset = 1'b0;
    for (int k = 0; k < N; k++) gcount[k] = 0;
    prev_gnt_any = 1'b0;
    bad_onehot   = 1'b0;
    back_to_back = 1'b0;
    req = 4'b1111;
    din = 32'h44332211;
    for (int c = 0; c < 20; c++) begin
      step();
      if (gnt != 4'b0000 && !$onehot(gnt)) bad_onehot = 1'b1;
      if (gnt != 4'b0000 && prev_gnt_any) back_to_back = 1'b1;
      prev_gnt_any = (gnt != 4'b0000);
      for (int k = 0; k < N; k++) if (gnt[k]) gcount[k]++;
    end
    req = '0;
    for (int k = 0; k < N; k++) chk($sformatf("fair src%0d served>=2", k), 32'(gcount[k] >= 2), 32'h1);
    chk("fair onehot", 32'(bad_onehot), 32'h0);
    chk("fair spacing", 32'(back_to_back), 32'h0);

    // Reset during a grant to requester 1 (ptr=1 beforehand so a stale ptr shows)
    reset = 1'b1; step(); reset = 1'b0;
    req = 4'b0001; din = 32'h0000005A;
    step();
    chk("rst-mid g0", 32'(gnt), 32'h1);
    req = 4'b0000;
    step();
    chk("rst-mid w0", 32'(out), 32'h5A);
    req = 4'b0010; din = 32'h0000FF5A;
    step();
    chk("rst-mid g1", 32'(gnt), 32'h2);
    reset = 1'b1; req = 4'b0000;
    step();
    chk_all("rst-mid after", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
    reset = 1'b0;
    step();
    chk("rst-mid no write", 32'(out), 32'h0);
    req = 4'b0011;
    step();
    chk("rst-mid ptr0 gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    step();
    chk_all("rst-mid write0", 4'b0000, 1'b0, 8'h5A, 1'b1, 2'd0);

    // Early drop: req[1] falls during its GRANT cycle, write still lands
    reset = 1'b1; step(); reset = 1'b0;
    req = 4'b0010; din = 32'h00007700;
    step();
    chk("drop gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    step();
    chk_all("drop write", 4'b0000, 1'b0, 8'h77, 1'b1, 2'd1);
    step();
    chk("drop no regrant", 32'({gnt, busy}), 32'h0);
    req = 4'b1011; req[1] = 1'b0;
    din = 32'hC0000000;
    step();
    chk("drop next gnt", 32'(gnt), 32'h8);
    req = 4'b0000;
    step();
    chk_all("drop next write", 4'b0000, 1'b0, 8'hC0, 1'b1, 2'd3);
    for (int c = 0; c < 3; c++) step();
    chk("hold out", 32'({out, out_valid}), 32'h181);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
